d64_sector_server: RTL and testbench

- Responder end of the sector-transfer interface driven by the drive-side SD controller. Serves 256-byte sector read/write requests (io_rd/io_wr with io_lba) from a byte-wide backing image memory.
- Streams read data to the controller via io_din/io_din_strobe and pulls write data via io_dout/io_dout_strobe.
- Sits between the drive emulation's SD controller and the disk-image store (BRAM or SDRAM port). Used standalone on FPGA-only builds and as the bench model for the controller.

---
 rtl/d64_sector_server_if.sv | 34 +++
 rtl/d64_sector_server.sv | 137 +++++++++++++
 tb/tb_d64_sector_server.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/d64_sector_server_if.sv
// Sector-transfer bus between the SD controller and the sector server,
// plus the byte-wide port into the disk-image store.
interface d64_sector_server_if #(
  parameter int ADDR_W = 24
);
  logic [31:0]       io_lba;
  logic              io_rd;
  logic              io_wr;
  logic              io_ack;
  logic              io_conf;
  logic              io_sdhc;
  logic [7:0]        io_din;
  logic              io_din_strobe;
  logic [7:0]        io_dout;
  logic              io_dout_strobe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  modport slave (
    input  io_lba, io_rd, io_wr, io_conf, io_sdhc, io_dout, mem_rdata, mem_ready,
    output io_ack, io_din, io_din_strobe, io_dout_strobe,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output io_lba, io_rd, io_wr, io_conf, io_sdhc, io_dout, mem_rdata, mem_ready,
    input  io_ack, io_din, io_din_strobe, io_dout_strobe,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/d64_sector_server.sv
// Serves 256-byte sector reads/writes for the drive SD controller out of a
// byte-wide image memory; out-of-range sectors read as zero and drop writes.
module d64_sector_server #(
  parameter int ADDR_W     = 24,
  parameter int LBA_LIMIT  = 683,
  parameter int STROBE_GAP = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  d64_sector_server_if.slave     bus,
  output logic                   busy
);

  typedef enum logic [2:0] {IDLE, RD_MEM, RD_OUT, WR_IN, WR_MEM, GAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [ADDR_W-9:0] sector_q, sector_d;
  logic              oor_q, oor_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        data_q, data_d;
  logic [3:0]        gap_q, gap_d;

  logic [31:0]       sector_full;
  logic              advance;
  logic              mem_rd, mem_wr, din_strobe, dout_strobe;
  state_t            resume;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sector_d    = sector_q;
    oor_d       = oor_q;
    is_wr_d     = is_wr_q;
    data_d      = data_q;
    gap_d       = gap_q;
    advance     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    din_strobe  = 1'b0;
    dout_strobe = 1'b0;
    sector_full = bus.io_sdhc ? bus.io_lba : {8'h00, bus.io_lba[31:8]};
    resume      = is_wr_q ? WR_IN : RD_MEM;

    case (state_q)
      IDLE: begin
        if (bus.io_rd || bus.io_wr) begin
          sector_d = sector_full[ADDR_W-9:0];
          oor_d    = (sector_full >= 32'(LBA_LIMIT)) || bus.io_conf;
          idx_d    = 8'h00;
          is_wr_d  = !bus.io_rd;
          state_d  = bus.io_rd ? RD_MEM : WR_IN;
        end
      end
      RD_MEM: begin
        mem_rd = !oor_q;
        if (oor_q) begin
          data_d  = 8'h00;
          state_d = RD_OUT;
        end else if (bus.mem_ready) begin
          data_d  = bus.mem_rdata;
          state_d = RD_OUT;
        end
      end
      RD_OUT: begin
        din_strobe = 1'b1;
        advance    = 1'b1;
      end
      WR_IN: begin
        dout_strobe = 1'b1;
        data_d      = bus.io_dout;
        if (oor_q) advance = 1'b1;
        else       state_d = WR_MEM;
      end
      WR_MEM: begin
        mem_wr = 1'b1;
        if (bus.mem_ready) advance = 1'b1;
      end
      GAP: begin
        if (gap_q == 4'(STROBE_GAP - 1)) state_d = resume;
        else                             gap_d   = gap_q + 4'd1;
      end
      DONE: begin
        if (!bus.io_rd && !bus.io_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Byte finished: close the sector or step to the next byte.
    if (advance) begin
      if (idx_q == 8'hFF) begin
        state_d = DONE;
      end else begin
        idx_d = idx_q + 8'd1;
        if (STROBE_GAP == 0) begin
          state_d = resume;
        end else begin
          state_d = GAP;
          gap_d   = 4'd0;
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sector_q <= '0;
      oor_q    <= 1'b0;
      is_wr_q  <= 1'b0;
      data_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sector_q <= sector_d;
      oor_q    <= oor_d;
      is_wr_q  <= is_wr_d;
      data_q   <= data_d;
      gap_q    <= gap_d;
    end
  end

  assign bus.io_ack         = (state_q != IDLE) && (state_q != DONE);
  assign bus.io_din         = data_q;
  assign bus.io_din_strobe  = din_strobe;
  assign bus.io_dout_strobe = dout_strobe;
  assign bus.mem_addr       = {sector_q, idx_q};
  assign bus.mem_rd         = mem_rd;
  assign bus.mem_wr         = mem_wr;
  assign bus.mem_wdata      = data_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_d64_sector_server.sv
// Randomized bench for d64_sector_server: a controller/memory responder pair
// and a sector-level image model decide what every strobe and byte must be.
module tb_d64_sector_server;
  localparam int ADDR_W = 24;
  localparam int LIMIT  = 683;
  localparam int SGAP   = 2;

  logic clk;
  logic reset;
  logic busy;

  d64_sector_server_if #(.ADDR_W(ADDR_W)) bus ();

  d64_sector_server #(.ADDR_W(ADDR_W), .LBA_LIMIT(LIMIT), .STROBE_GAP(SGAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] img[int];      // contents of the responder's memory
  logic [7:0] ref_img[int];  // what the image should hold
  logic [7:0] rd_q[$];
  int         addr_q[$];
  logic [7:0] wr_buf[256];
  int din_cnt, dout_cnt, mem_rd_cyc, mem_wr_cyc, cyc, last_strobe;
  bit both_hi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] img_at(input int a);
    return img.exists(a) ? img[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_at(input int a);
    return ref_img.exists(a) ? ref_img[a] : 8'h00;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input int sec, input bit xor_pat);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = xor_pat ? (8'(i) ^ 8'h5A) : 8'($urandom);
      img[sec * 256 + i]     = v;
      ref_img[sec * 256 + i] = v;
    end
  endtask

  // Controller-side monitor: collects strobes, supplies write bytes on fetch.
  initial begin
    bus.io_dout = 8'h00;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.io_din_strobe) begin
        rd_q.push_back(bus.io_din);
        din_cnt++;
        last_strobe = cyc;
      end
      if (bus.io_dout_strobe) begin
        bus.io_dout = wr_buf[dout_cnt % 256];
        dout_cnt++;
        last_strobe = cyc;
      end
      if (bus.mem_rd && bus.mem_wr) both_hi = 1'b1;
      if (bus.mem_rd) mem_rd_cyc++;
      if (bus.mem_wr) mem_wr_cyc++;
    end
  end

  // Memory responder: random latency, one-cycle ready, occasional stray ready.
  initial begin
    int pend;
    pend = -1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (!(bus.mem_rd || bus.mem_wr)) begin
        pend = -1;
        if ($urandom_range(0, 15) == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = 8'($urandom);
        end
      end else begin
        if (pend < 0) pend = int'($urandom_range(0, 3));
        if (pend == 0) begin
          int a;
          a = int'(bus.mem_addr);
          addr_q.push_back(a);
          if (bus.mem_wr) img[a] = bus.mem_wdata;
          else            bus.mem_rdata = img_at(a);
          bus.mem_ready = 1'b1;
          pend = -1;
        end else begin
          pend--;
        end
      end
    end
  end

  task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba, input bit sdhc,
                      input bit conf, input bit hold, input bit idx_pat, input int abort_at);
    logic [31:0] sec;
    bit oor;
    int base, t, n0, m0, diff;
    logic [7:0] exp;
    sec  = sdhc ? lba : (lba >> 8);
    oor  = (sec >= 32'(LIMIT)) || conf;
    base = int'({sec[15:0], 8'h00});
    for (int i = 0; i < 256; i++) wr_buf[i] = idx_pat ? 8'(i) : 8'($urandom);
    din_cnt = 0; dout_cnt = 0; mem_rd_cyc = 0; mem_wr_cyc = 0; both_hi = 1'b0;
    rd_q.delete();
    addr_q.delete();

    bus.io_lba = lba; bus.io_sdhc = sdhc; bus.io_conf = conf;
    bus.io_rd = rd; bus.io_wr = wr;
    check("ack_before_accept", bus.io_ack, 1'b0);
    tick();
    check("ack_rise", bus.io_ack, 1'b1);
    check("busy_run", busy, 1'b1);
    if (!hold) begin bus.io_rd = 1'b0; bus.io_wr = 1'b0; end

    if (abort_at >= 0) begin
      t = 0;
      while (din_cnt < abort_at && t < 20000) begin tick(); t++; end
      check("abort_reach", din_cnt, abort_at);
      reset = 1'b0;
      tick();
      check("rst_ack", bus.io_ack, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_din_strobe", bus.io_din_strobe, 1'b0);
      check("rst_mem_rd", bus.mem_rd, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_io_din", bus.io_din, 8'h00);
      reset = 1'b1;
      bus.io_rd = 1'b0; bus.io_wr = 1'b0;
      n0 = din_cnt; m0 = mem_rd_cyc;
      repeat (30) tick();
      check("abort_no_strobe", din_cnt, n0);
      check("abort_no_mem", mem_rd_cyc, m0);
      return;
    end

    t = 0;
    while (bus.io_ack && t < 20000) begin tick(); t++; end
    check("ack_timeout", t < 20000, 1'b1);
    diff = cyc - last_strobe;
    if (rd || oor) check("ack_fall_after_strobe", diff, 1);
    else           check("ack_fall_after_write", diff >= 2, 1'b1);

    if (rd) begin
      check("din_count", din_cnt, 256);
      check("dout_count", dout_cnt, 0);
      for (int i = 0; i < rd_q.size() && i < 256; i++) begin
        exp = oor ? 8'h00 : ref_at(base + i);
        check($sformatf("rd_byte_%0d", i), rd_q[i], exp);
      end
    end else begin
      check("dout_count", dout_cnt, 256);
      check("din_count", din_cnt, 0);
      if (!oor) for (int i = 0; i < 256; i++) ref_img[base + i] = wr_buf[i];
      for (int i = 0; i < 256; i++)
        check($sformatf("img_byte_%0d", i), img_at(base + i), ref_at(base + i));
    end

    if (oor) begin
      check("oor_mem_cycles", mem_rd_cyc + mem_wr_cyc, 0);
      check("oor_mem_access", addr_q.size(), 0);
    end else begin
      check("mem_access_count", addr_q.size(), 256);
      for (int i = 0; i < addr_q.size() && i < 256; i++)
        check($sformatf("mem_addr_%0d", i), addr_q[i], base + i);
    end
    check("rd_wr_overlap", both_hi, 1'b0);

    n0 = din_cnt + dout_cnt;
    m0 = mem_rd_cyc + mem_wr_cyc;
    if (hold) begin
      repeat (10) tick();
      check("no_retrigger", din_cnt + dout_cnt, n0);
      check("done_busy", busy, 1'b1);
      check("done_ack", bus.io_ack, 1'b0);
      bus.io_rd = 1'b0; bus.io_wr = 1'b0;
    end
    tick();
    check("idle_busy", busy, 1'b0);
    repeat (3) tick();
    check("no_stray_mem", mem_rd_cyc + mem_wr_cyc, m0);
    check("no_stray_strobe", din_cnt + dout_cnt, n0);
  endtask

  initial begin
    logic [31:0] sec, lba;
    bit sdhc;
    reset = 1'b0;
    bus.io_lba = '0; bus.io_rd = 1'b0; bus.io_wr = 1'b0;
    bus.io_conf = 1'b0; bus.io_sdhc = 1'b1;
    din_cnt = 0; dout_cnt = 0; mem_rd_cyc = 0; mem_wr_cyc = 0;
    last_strobe = 0; both_hi = 1'b0;
    repeat (3) tick();
    check("reset_ack", bus.io_ack, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_dout_strobe", bus.io_dout_strobe, 1'b0);
    check("reset_mem_wr", bus.mem_wr, 1'b0);
    check("reset_mem_wdata", bus.mem_wdata, 8'h00);
    check("reset_mem_addr", bus.mem_addr, 0);
    reset = 1'b1;
    tick();

    preload(17, 1'b1);
    xfer(1, 0, 32'd17, 1, 0, 0, 0, -1);
    if (rd_q.size() > 1) begin
      check("sector17_first", rd_q[0], 8'h5A);
      check("sector17_second", rd_q[1], 8'h5B);
    end else begin
      check("sector17_data_present", rd_q.size(), 256);
    end
    xfer(0, 1, 32'd3, 1, 0, 0, 1, -1);
    check("sector3_last", img_at(32'h3FF), 8'hFF);
    xfer(1, 0, 32'd3, 1, 0, 0, 0, -1);
    xfer(1, 0, 32'd683, 1, 0, 0, 0, -1);
    xfer(0, 1, 32'd700, 1, 0, 0, 0, -1);
    preload(10, 1'b0);
    xfer(1, 0, 32'h0000_0A00, 0, 0, 0, 0, -1);
    xfer(1, 1, 32'd10, 1, 0, 1, 0, -1);
    xfer(1, 0, 32'd17, 1, 1, 0, 0, -1);
    xfer(1, 0, 32'd682, 1, 0, 0, 0, -1);
    xfer(1, 0, 32'd17, 1, 0, 0, 0, 100);
    preload(5, 1'b0);
    xfer(1, 0, 32'd5, 1, 0, 0, 0, -1);

    for (int k = 0; k < 6; k++) begin
      sec  = 32'($urandom_range(0, 719));
      sdhc = 1'($urandom_range(0, 1));
      lba  = sdhc ? sec : ((sec << 8) | 32'($urandom_range(0, 255)));
      xfer(1'($urandom_range(0, 1)), 1'b1, lba, sdhc, $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)), 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
